// File: rtl/neuron_learn_seq.sv
// Sequential learn-neuron: one time-multiplexed MAC, hard-sigmoid output, in-place delta-rule update.
// Optional NEURON_WEIGHT_LOAD_EN adds a direct weight/bias load port usable while idle.
module neuron_learn_seq #(
  parameter int N        = 16,
  parameter int IN_W     = 8,
  parameter int WT_W     = 16,
  parameter int WT_FRAC  = 12,
  parameter int LR_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 learn,
  input  logic [N*IN_W-1:0]    in_vec,
  input  logic [IN_W-1:0]      expected_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_W-1:0]      out,
  output logic [N*WT_W-1:0]    weights,
  output logic [WT_W-1:0]      bias,
  output logic                 exp_valid,
  output logic [N*IN_W-1:0]    expected_in
`ifdef NEURON_WEIGHT_LOAD_EN
  ,
  input  logic                 wt_load,
  input  logic [$clog2(N+1)-1:0] wt_idx,
  input  logic [WT_W-1:0]      wt_data
`endif
);

  localparam int CNT_W  = $clog2(N+1);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W  = IN_W + WT_W + $clog2(N) + 2;
  localparam int PRD_W  = IN_W + 1 + WT_W;
  localparam int EP_W   = (IN_W + 1) + (IN_W + 2);
  localparam int SUM_W  = ((EP_W > WT_W) ? EP_W : WT_W) + 2;
  localparam int EW_W   = IN_W + 1 + WT_W;
  localparam int XS_W   = EW_W + 2;
  localparam int UPD_SH = 2*IN_W - WT_FRAC + LR_SHIFT;
  localparam int EXP_SH = WT_FRAC + LR_SHIFT;
  localparam int HALF   = 1 << (IN_W - 1);
  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_U = CNT_W'(N);

  typedef enum logic [2:0] {IDLE, ACC, ACT, OUT, UPD} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [IN_W-1:0]         x_reg  [N];
  logic signed [WT_W-1:0]  w_reg  [N];
  logic [IN_W-1:0]         shadow [N];
  logic signed [WT_W-1:0]  b_reg;
  logic [IN_W-1:0]         target;
  logic                    learn_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [IN_W:0]    err;
  logic                    load_busy;

  logic [IN_W-1:0]         x_sel;
  logic signed [WT_W-1:0]  w_sel;
  logic signed [PRD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_sh, s_val;
  logic [IN_W-1:0]         out_next;
  logic signed [IN_W:0]    err_next;
  logic                    bias_step;
  logic [IN_W:0]           upd_in;
  logic signed [WT_W-1:0]  upd_w;
  logic signed [EP_W-1:0]  ep, delta;
  logic signed [WT_W-1:0]  new_w;
  logic signed [EW_W-1:0]  ew, ew_sh;
  logic signed [XS_W-1:0]  xs;
  logic [IN_W-1:0]         xi_next;

  function automatic logic signed [WT_W-1:0] sat_w(input logic signed [SUM_W-1:0] v);
    if ((&v[SUM_W-1:WT_W-1]) || (~|v[SUM_W-1:WT_W-1]))
      return v[WT_W-1:0];
    else if (v[SUM_W-1])
      return {1'b1, {(WT_W-1){1'b0}}};
    else
      return {1'b0, {(WT_W-1){1'b1}}};
  endfunction

  function automatic logic [IN_W-1:0] clamp_x(input logic signed [XS_W-1:0] v);
    if (v[XS_W-1])
      return '0;
    else if (|v[XS_W-2:IN_W])
      return '1;
    else
      return v[IN_W-1:0];
  endfunction

`ifdef NEURON_WEIGHT_LOAD_EN
  assign load_busy = wt_load;
`else
  assign load_busy = 1'b0;
`endif

  assign idx = cnt[IDX_W-1:0];

  always_comb begin
    for (int k = 0; k < N; k++) weights[k*WT_W +: WT_W] = w_reg[k];
  end
  assign bias = b_reg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !load_busy;
        if (in_valid && !load_busy) state_next = ACC;
      end
      ACC:  if (cnt == LAST_I) state_next = ACT;
      ACT:  state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = learn_reg ? UPD : IDLE;
      end
      UPD:  if (cnt == LAST_U) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared element path: MAC product while accumulating; delta and back-propagated target while updating.
  always_comb begin
    x_sel     = x_reg[idx];
    w_sel     = w_reg[idx];
    prod      = PRD_W'($signed({1'b0, x_sel})) * PRD_W'(w_sel);
    acc_sh    = acc >>> WT_FRAC;
    s_val     = acc_sh + ACC_W'(HALF);
    if (s_val[ACC_W-1])
      out_next = '0;
    else if (|s_val[ACC_W-2:IN_W])
      out_next = '1;
    else
      out_next = s_val[IN_W-1:0];
    err_next  = $signed({1'b0, target}) - $signed({1'b0, out_next});
    bias_step = (cnt == LAST_U);
    upd_in    = bias_step ? {1'b1, {IN_W{1'b0}}} : {1'b0, x_sel};
    upd_w     = bias_step ? b_reg : w_sel;
    ep        = EP_W'(err) * EP_W'($signed({1'b0, upd_in}));
    delta     = ep >>> UPD_SH;
    new_w     = sat_w(SUM_W'(upd_w) + SUM_W'(sat_w(SUM_W'(delta))));
    ew        = EW_W'(err) * EW_W'(w_sel);
    ew_sh     = ew >>> EXP_SH;
    xs        = XS_W'($signed({1'b0, x_sel})) + XS_W'(ew_sh);
    xi_next   = clamp_x(xs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      err         <= '0;
      out         <= '0;
      b_reg       <= '0;
      target      <= '0;
      learn_reg   <= 1'b0;
      exp_valid   <= 1'b0;
      expected_in <= '0;
      for (int k = 0; k < N; k++) begin
        x_reg[k]  <= '0;
        w_reg[k]  <= '0;
        shadow[k] <= '0;
      end
    end else begin
      exp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid && in_ready) begin
            for (int k = 0; k < N; k++) x_reg[k] <= in_vec[k*IN_W +: IN_W];
            target    <= expected_out;
            learn_reg <= learn;
            acc       <= ACC_W'(b_reg) <<< IN_W;
          end
`ifdef NEURON_WEIGHT_LOAD_EN
          else if (wt_load && (wt_idx <= LAST_U)) begin
            if (wt_idx == LAST_U) b_reg <= wt_data;
            else                  w_reg[wt_idx[IDX_W-1:0]] <= wt_data;
          end
`endif
        end
        ACC: begin
          acc <= acc + ACC_W'(prod);
          cnt <= (cnt == LAST_I) ? '0 : cnt + CNT_W'(1);
        end
        ACT: begin
          out <= out_next;
          err <= err_next;
        end
        OUT: cnt <= '0;
        // The last weight step publishes the shadow so exp_valid lines up with the bias step.
        UPD: begin
          cnt <= cnt + CNT_W'(1);
          if (bias_step) begin
            b_reg <= new_w;
          end else begin
            w_reg[idx]  <= new_w;
            shadow[idx] <= xi_next;
            if (cnt == LAST_I) begin
              exp_valid <= 1'b1;
              for (int k = 0; k < N; k++)
                expected_in[k*IN_W +: IN_W] <= (k == N - 1) ? xi_next : shadow[k];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_learn_seq.sv
// Randomised scoreboard bench for neuron_learn_seq against an integer reference model.
// The weight-load sequence runs only when NEURON_WEIGHT_LOAD_EN is defined.
module tb_neuron_learn_seq;
  localparam int N        = 16;
  localparam int IN_W     = 8;
  localparam int WT_W     = 16;
  localparam int WT_FRAC  = 12;
  localparam int LR_SHIFT = 4;
  localparam int CW       = N * WT_W;
  localparam int XMAX     = (1 << IN_W) - 1;
  localparam int WMAX     = (1 << (WT_W - 1)) - 1;
  localparam int WMIN     = -(1 << (WT_W - 1));

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, learn;
  logic [N*IN_W-1:0]    in_vec, expected_in;
  logic [IN_W-1:0]      expected_out, out;
  logic                 out_valid, out_ready, exp_valid;
  logic [N*WT_W-1:0]    weights;
  logic [WT_W-1:0]      bias;
`ifdef NEURON_WEIGHT_LOAD_EN
  logic                 wt_load;
  logic [$clog2(N+1)-1:0] wt_idx;
  logic [WT_W-1:0]      wt_data;
`endif

  neuron_learn_seq #(.N(N), .IN_W(IN_W), .WT_W(WT_W), .WT_FRAC(WT_FRAC), .LR_SHIFT(LR_SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .learn(learn),
    .in_vec(in_vec), .expected_out(expected_out), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .weights(weights), .bias(bias), .exp_valid(exp_valid), .expected_in(expected_in)
`ifdef NEURON_WEIGHT_LOAD_EN
    , .wt_load(wt_load), .wt_idx(wt_idx), .wt_data(wt_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IN_W-1:0]   out;
    logic              learn;
    logic [N*IN_W-1:0] ein;
    logic [N*WT_W-1:0] w;
    logic [WT_W-1:0]   b;
  } txn_t;

  txn_t sb[$];
  int   total_checks = 0;
  int   passed_checks = 0;
  int   mw[N];
  int   mb = 0;
  int   last_out = 0;
  bit   hold_low = 0;
  bit   upd_pend = 0;
  bit   bias_chk = 0;
  int   upd_wait = 0;
  txn_t cur;

  task automatic check_output(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [N*IN_W-1:0] rand_vec();
    logic [N*IN_W-1:0] v;
    for (int i = 0; i < N; i++) v[i*IN_W +: IN_W] = IN_W'($urandom);
    return v;
  endfunction

  // Reference neuron: whole-vector integer arithmetic, floor shifts via >>> on int.
  task automatic model_push(input logic [N*IN_W-1:0] v, input logic [IN_W-1:0] e, input logic l);
    txn_t t;
    int acc, o, err, x, d, tmp;
    acc = mb * (1 << IN_W);
    for (int i = 0; i < N; i++) begin
      x = int'(v[i*IN_W +: IN_W]);
      acc += x * mw[i];
    end
    o   = clampi((acc >>> WT_FRAC) + (1 << (IN_W - 1)), 0, XMAX);
    err = int'(e) - o;
    t.out   = o[IN_W-1:0];
    t.learn = l;
    t.ein   = '0;
    if (l) begin
      for (int i = 0; i < N; i++) begin
        x   = int'(v[i*IN_W +: IN_W]);
        tmp = clampi(x + ((err * mw[i]) >>> (WT_FRAC + LR_SHIFT)), 0, XMAX);
        t.ein[i*IN_W +: IN_W] = tmp[IN_W-1:0];
        d     = clampi((err * x) >>> (2*IN_W - WT_FRAC + LR_SHIFT), WMIN, WMAX);
        mw[i] = clampi(mw[i] + d, WMIN, WMAX);
      end
      d  = clampi((err * (1 << IN_W)) >>> (2*IN_W - WT_FRAC + LR_SHIFT), WMIN, WMAX);
      mb = clampi(mb + d, WMIN, WMAX);
    end
    for (int i = 0; i < N; i++) begin
      tmp = mw[i];
      t.w[i*WT_W +: WT_W] = tmp[WT_W-1:0];
    end
    tmp = mb;
    t.b = tmp[WT_W-1:0];
    last_out = o;
    sb.push_back(t);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mw[i] = 0;
    mb = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check_output("idle_timeout", CW'(in_ready), CW'(1'b1));
  endtask

  task automatic apply_stimulus(input logic [N*IN_W-1:0] v, input logic [IN_W-1:0] e, input logic l);
    int k, lat;
    @(negedge clk);
    in_vec = v; expected_out = e; learn = l; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check_output("accept_timeout", CW'(in_ready), CW'(1'b1));
      in_valid = 1'b0;
      return;
    end
    model_push(v, e, l);
    @(negedge clk);
    in_valid = 1'b0; in_vec = rand_vec(); expected_out = IN_W'($urandom); learn = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < N + 10) begin
      @(negedge clk);
      lat++;
    end
    check_output("out_latency", CW'(lat), CW'(N + 2));
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expected result per output handshake and tracks the update/exp_valid window.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        upd_pend = 0;
        bias_chk = 0;
      end else begin
        if (bias_chk) begin
          bias_chk = 0;
          check_output("upd_weights", CW'(weights), CW'(cur.w));
          check_output("upd_bias", CW'(bias), CW'(cur.b));
          check_output("exp_pulse", CW'(exp_valid), CW'(1'b0));
        end
        if (upd_pend) begin
          upd_wait++;
          if (exp_valid) begin
            check_output("exp_latency", CW'(upd_wait), CW'(N + 1));
            check_output("expected_in", CW'(expected_in), CW'(cur.ein));
            upd_pend = 0;
            bias_chk = 1;
          end else if (upd_wait > N + 1) begin
            check_output("exp_timeout", CW'(exp_valid), CW'(1'b1));
            upd_pend = 0;
          end
        end else if (exp_valid) begin
          check_output("exp_spurious", CW'(exp_valid), CW'(1'b0));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_output("out_unexpected", CW'(out_valid), CW'(1'b0));
          end else begin
            cur = sb.pop_front();
            check_output("out", CW'(out), CW'(cur.out));
            if (cur.learn) begin
              upd_pend = 1;
              upd_wait = 0;
            end else begin
              check_output("hold_weights", CW'(weights), CW'(cur.w));
              check_output("hold_bias", CW'(bias), CW'(cur.b));
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    logic [N*IN_W-1:0] v;
    rst = 1'b1; in_valid = 1'b0; learn = 1'b0; in_vec = '0; expected_out = '0;
`ifdef NEURON_WEIGHT_LOAD_EN
    wt_load = 1'b0; wt_idx = '0; wt_data = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    check_output("rst_weights", CW'(weights), CW'(0));
    check_output("rst_bias", CW'(bias), CW'(0));
    check_output("rst_out", CW'(out), CW'(0));
    check_output("rst_out_valid", CW'(out_valid), CW'(0));
    check_output("rst_exp_valid", CW'(exp_valid), CW'(0));
    check_output("rst_expected_in", CW'(expected_in), CW'(0));
    check_output("rst_in_ready", CW'(in_ready), CW'(1'b1));

    $display("[TB] directed vectors");
    apply_stimulus(rand_vec(), IN_W'($urandom), 1'b0);
    apply_stimulus('1, 8'd255, 1'b1);
    apply_stimulus('1, 8'd255, 1'b0);

`ifdef NEURON_WEIGHT_LOAD_EN
    $display("[TB] weight load");
    wait_idle();
    wt_load = 1'b1; wt_idx = '0; wt_data = 16'h7fff;
    #1;
    check_output("load_in_ready", CW'(in_ready), CW'(1'b0));
    @(negedge clk);
    wt_load = 1'b0;
    mw[0] = 32767;
    v = '0;
    v[IN_W-1:0] = 8'hff;
    apply_stimulus(v, 8'd255, 1'b1);
`endif

    $display("[TB] output stall");
    wait_idle();
    hold_low = 1;
    apply_stimulus(rand_vec(), IN_W'($urandom), 1'b0);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_vec = rand_vec();
      check_output("stall_out", CW'(out), CW'(last_out[IN_W-1:0]));
      check_output("stall_valid", CW'(out_valid), CW'(1'b1));
      check_output("stall_in_ready", CW'(in_ready), CW'(1'b0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold_low = 0;

    $display("[TB] random vectors");
    repeat (40) apply_stimulus(rand_vec(), IN_W'($urandom), 1'($urandom));

    $display("[TB] reset during update");
    apply_stimulus(rand_vec(), IN_W'($urandom), 1'b1);
    k = 0;
    while (!(out_valid && out_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("midrst_weights", CW'(weights), CW'(0));
    check_output("midrst_bias", CW'(bias), CW'(0));
    check_output("midrst_out_valid", CW'(out_valid), CW'(0));
    check_output("midrst_in_ready", CW'(in_ready), CW'(1'b1));
    rst = 1'b0;
    model_reset();
    repeat (4) apply_stimulus(rand_vec(), IN_W'($urandom), 1'($urandom));

    k = 0;
    while ((sb.size() != 0 || upd_pend || bias_chk) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0 || upd_pend || bias_chk)
      check_output("drain_timeout", CW'({sb.size() != 0, upd_pend, bias_chk}), CW'(0));
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
